// File: rtl/vga_fb_pkg.sv
// Shared constants for the frame-buffer arbiter: default widths, grant encoding and
// a width helper for the starvation counter.
package vga_fb_pkg;

  localparam int unsigned DEFAULT_ADDR_BITS = 16;
  localparam int unsigned DEFAULT_DATA_W    = 8;

  localparam logic [1:0] GNT_IDLE  = 2'd0;
  localparam logic [1:0] GNT_READ  = 2'd1;
  localparam logic [1:0] GNT_WRITE = 2'd2;

  // Bits needed to hold values 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < value) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Posted-write FIFO holding {address, data} entries from the image loader until a
// non-read cycle lets them drain into the frame buffer.
module fb_wr_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads always win, loader writes are
// posted into a small FIFO and drained whenever the display is not reading.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = DEFAULT_ADDR_BITS,
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ready,
  output logic                 wr_idle,
  output logic                 wr_starved,
  output logic                 ram_enable,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);

  localparam int unsigned ENTRY_W = ADDR_BITS + DATA_W;
  localparam int unsigned FCNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned SCNT_W  = clog2(STARVE_LIMIT + 1);

  logic [1:0]           gnt;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic [FCNT_W-1:0]    fifo_count;
  logic [ADDR_BITS-1:0] head_addr;
  logic [DATA_W-1:0]    head_data;
  logic                 rd_valid_q;
  logic [SCNT_W-1:0]    starve_q, starve_d;

  assign head_addr = fifo_dout[ENTRY_W-1:DATA_W];
  assign head_data = fifo_dout[DATA_W-1:0];

  // Registered occupancy only, so a pop while full does not reopen the port early.
  assign wr_ready  = !fifo_full;
  assign wr_idle   = (fifo_count == '0);
  assign fifo_push = wr_req && wr_ready;
  assign fifo_pop  = (gnt == GNT_WRITE);

  fb_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_wr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({wr_addr, wr_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    gnt = GNT_IDLE;
    if (!reset) begin
      if (rd_req)           gnt = GNT_READ;
      else if (!fifo_empty) gnt = GNT_WRITE;
    end
  end

  always_comb begin
    ram_enable = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    case (gnt)
      GNT_READ: begin
        ram_enable = 1'b1;
        ram_addr   = rd_addr;
      end
      GNT_WRITE: begin
        ram_enable = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = head_addr;
        ram_wdata  = head_data;
      end
      default: ;
    endcase
  end

  assign rd_data  = ram_rdata;
  assign rd_valid = rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) rd_valid_q <= 1'b0;
    else       rd_valid_q <= (gnt == GNT_READ);
  end

  // Counts cycles where queued writes sit behind display reads.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || (gnt == GNT_WRITE)) begin
      starve_d = '0;
    end else if (rd_req && (starve_q != SCNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign wr_starved = (starve_q == SCNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed table, hand sequences for
// starvation and mid-flight reset, then random traffic against a queue-based model.
module tb_vga_fb_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr, ram_addr;
  logic [DW-1:0] rd_data, wr_data, ram_wdata, ram_rdata;
  logic          rd_valid, wr_ready, wr_idle, wr_starved, ram_enable, ram_we;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_BITS    (AW),
    .DATA_W       (DW),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_idle    (wr_idle),
    .wr_starved (wr_starved),
    .ram_enable (ram_enable),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // BRAM with registered read data, preloaded with a known pattern.
  logic [DW-1:0] bram [65536];
  initial begin
    for (int i = 0; i < 65536; i++) bram[i] = 8'(i) ^ 8'h3C;
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_enable) begin
        if (ram_we) bram[ram_addr] <= ram_wdata;
        else        ram_rdata <= bram[ram_addr];
      end
    end
  end

  // Reference model: pending-write queue, expected memory image, blocked-cycle count.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic [DW-1:0] ref_mem [65536];
  int            starve = 0;
  bit            exp_rv = 1'b0;
  logic [DW-1:0] exp_rd = '0;
  int            checks = 0;
  int            errors = 0;

  typedef struct {
    bit            rst, rq, wq;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    bit            tab, chk_st;
    bit            en, we, rdy, idle, rv, st;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t iv(bit rst, bit rq, logic [AW-1:0] ra, bit wq,
                              logic [AW-1:0] wa, logic [DW-1:0] wd);
    vec_t v;
    v = '{default: '0};
    v.rst = rst; v.rq = rq; v.ra = ra; v.wq = wq; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  function automatic vec_t tv(bit rst, bit rq, logic [AW-1:0] ra, bit wq, logic [AW-1:0] wa,
                              logic [DW-1:0] wd, bit en, bit we, logic [AW-1:0] addr,
                              logic [DW-1:0] wdata, bit rdy, bit idle, bit rv,
                              logic [DW-1:0] rd);
    vec_t v;
    v = iv(rst, rq, ra, wq, wa, wd);
    v.tab = 1'b1; v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
    v.rdy = rdy; v.idle = idle; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  function automatic vec_t sv(bit rq, logic [AW-1:0] ra, bit wq, logic [AW-1:0] wa,
                              logic [DW-1:0] wd, bit st);
    vec_t v;
    v = iv(1'b0, rq, ra, wq, wa, wd);
    v.chk_st = 1'b1; v.st = st;
    return v;
  endfunction

  task automatic do_cycle(input vec_t v);
    bit            e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            n;
    bit            wgrant;
    @(negedge clk);
    reset = v.rst; rd_req = v.rq; rd_addr = v.ra;
    wr_req = v.wq; wr_addr = v.wa; wr_data = v.wd;
    #1;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (!v.rst) begin
      if (v.rq) begin
        e_en = 1'b1; e_addr = v.ra;
      end else if (q.size() > 0) begin
        e_en = 1'b1; e_we = 1'b1; e_addr = q[0].a; e_wdata = q[0].d;
      end
    end
    chk("ram_enable", ram_enable, e_en);
    chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("wr_ready", wr_ready, q.size() < DEPTH);
    chk("wr_idle", wr_idle, q.size() == 0);
    chk("wr_starved", wr_starved, starve == LIMIT);
    chk("rd_valid", rd_valid, exp_rv);
    if (exp_rv) chk("rd_data", rd_data, exp_rd);
    if (v.tab) begin
      chk("tab_enable", ram_enable, v.en);
      chk("tab_we", ram_we, v.we);
      chk("tab_addr", ram_addr, v.addr);
      chk("tab_wdata", ram_wdata, v.wdata);
      chk("tab_ready", wr_ready, v.rdy);
      chk("tab_idle", wr_idle, v.idle);
      chk("tab_rd_valid", rd_valid, v.rv);
      if (v.rv) chk("tab_rd_data", rd_data, v.rd);
    end
    if (v.tab || v.chk_st) chk("seq_starved", wr_starved, v.st);
    @(posedge clk);
    if (v.rst) begin
      q.delete();
      starve = 0;
      exp_rv = 1'b0;
    end else begin
      n      = q.size();
      wgrant = !v.rq && (n > 0);
      exp_rv = v.rq;
      if (v.rq) exp_rd = ref_mem[v.ra];
      if (n == 0 || wgrant)           starve = 0;
      else if (v.rq && starve < LIMIT) starve++;
      if (wgrant) begin
        ref_mem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (v.wq && n < DEPTH) q.push_back({v.wa, v.wd});
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);

    // Reset, then ten idle cycles.
    tbl.push_back(tv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // Single posted write drains on the next free cycle.
    tbl.push_back(tv(0, 0, 0, 1, 'h10, 'hA5, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 1, 1, 'h10, 'hA5, 1, 0, 0, 0));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // Reads block five offered writes; only four fit, then drain in order.
    tbl.push_back(tv(0, 1, 'h100, 1, 'h20, 'h11, 1, 0, 'h100, 0, 1, 1, 0, 0));
    tbl.push_back(tv(0, 1, 'h100, 1, 'h21, 'h12, 1, 0, 'h100, 0, 1, 0, 1, 'h3C));
    tbl.push_back(tv(0, 1, 'h100, 1, 'h22, 'h13, 1, 0, 'h100, 0, 1, 0, 1, 'h3C));
    tbl.push_back(tv(0, 1, 'h100, 1, 'h23, 'h14, 1, 0, 'h100, 0, 1, 0, 1, 'h3C));
    tbl.push_back(tv(0, 1, 'h100, 1, 'h24, 'h15, 1, 0, 'h100, 0, 0, 0, 1, 'h3C));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 1, 1, 'h20, 'h11, 0, 0, 1, 'h3C));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 1, 1, 'h21, 'h12, 1, 0, 0, 0));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 1, 1, 'h22, 'h13, 1, 0, 0, 0));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 1, 1, 'h23, 'h14, 1, 0, 0, 0));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    // Back-to-back reads, including read-back of drained and rejected writes.
    tbl.push_back(tv(0, 1, 'h0, 0, 0, 0, 1, 0, 'h0, 0, 1, 1, 0, 0));
    tbl.push_back(tv(0, 1, 'h1, 0, 0, 0, 1, 0, 'h1, 0, 1, 1, 1, 'h3C));
    tbl.push_back(tv(0, 1, 'h2, 0, 0, 0, 1, 0, 'h2, 0, 1, 1, 1, 'h3D));
    tbl.push_back(tv(0, 1, 'h10, 0, 0, 0, 1, 0, 'h10, 0, 1, 1, 1, 'h3E));
    tbl.push_back(tv(0, 1, 'h24, 0, 0, 0, 1, 0, 'h24, 0, 1, 1, 1, 'hA5));
    tbl.push_back(tv(0, 1, 'h23, 0, 0, 0, 1, 0, 'h23, 0, 1, 1, 1, 'h18));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h14));
    tbl.push_back(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    foreach (tbl[i]) do_cycle(tbl[i]);

    // Starvation: one queued write held off by ten read cycles.
    do_cycle(sv(0, 0, 1, 'h30, 'h77, 0));
    for (int k = 1; k <= 10; k++) do_cycle(sv(1, 16'(32'h40 + k), 0, 0, 0, k >= 9));
    do_cycle(sv(0, 0, 0, 0, 0, 1));
    do_cycle(sv(0, 0, 0, 0, 0, 0));

    // Reset with three writes queued: none may reach the BRAM.
    for (int i = 0; i < 3; i++) do_cycle(iv(0, 1, 'h200, 1, 16'(32'h50 + i), 8'(32'h90 + i)));
    do_cycle(iv(1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) do_cycle(tv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++) begin
      chk("bram_untouched", bram[16'(32'h50 + i)], 8'(32'h50 + i) ^ 8'h3C);
    end

    // Random traffic against the model; narrow address range to exercise hazards.
    for (int i = 0; i < 3000; i++) begin
      do_cycle(iv($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6,
                  16'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                  16'($urandom_range(0, 31)), 8'($urandom)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares the single port of the image frame-buffer BRAM between two requesters: the VGA scan-out reader and an image loader that writes pixels.
- Display reads have absolute priority, so the pixel pipeline never misses a cycle.
- Loader writes are posted into a small FIFO and drained in cycles with no read request (blanking intervals).
- Sits between the VGA timing/sprite logic and the BRAM instance, and drives the BRAM's enable, write-enable, address and data pins.

Parameters:
- ADDR_BITS, 16, BRAM address width.
- DATA_W, 8, pixel width (RGB 3:3:2).
- DEPTH, 4, posted-write FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 1024, consecutive blocked cycles before the starvation flag asserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  display requests a read this cycle.
- rd_addr  in  ADDR_BITS  display read address.
- rd_data  out  DATA_W  read data; pass-through of ram_rdata, valid only when rd_valid=1.
- rd_valid  out  1  registered; high one cycle after a granted read.
- wr_req  in  1  loader write request.
- wr_addr  in  ADDR_BITS  loader write address.
- wr_data  in  DATA_W  loader write data.
- wr_ready  out  1  FIFO can accept; a write is accepted when wr_req && wr_ready.
- wr_idle  out  1  FIFO empty, so no posted writes are outstanding.
- wr_starved  out  1  pending writes blocked for at least STARVE_LIMIT cycles.
- ram_enable  out  1  BRAM enable.
- ram_we  out  1  BRAM write enable.
- ram_addr  out  ADDR_BITS  BRAM address.
- ram_wdata  out  DATA_W  BRAM write data.
- ram_rdata  in  DATA_W  BRAM registered read data (1-cycle latency).

Behaviour:
- Clocking and reset:
  - One clock domain; all state updates on the rising edge of clk.
  - reset is synchronous and active-high.
- Reset values:
  - FIFO empty (count=0, pointers=0); wr_ready=1; wr_idle=1.
  - rd_valid=0; starvation counter=0; wr_starved=0.
  - While reset=1: ram_enable=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Grant logic (combinational, evaluated every cycle; the ram_* outputs are combinational from it):
  - READ, when rd_req=1: ram_enable=1, ram_we=0, ram_addr=rd_addr, ram_wdata=0.
  - WRITE, when rd_req=0 and FIFO not empty: ram_enable=1, ram_we=1, ram_addr/ram_wdata = FIFO head; the head is popped at this edge.
  - IDLE, otherwise: ram_enable=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Read latency:
  - rd_valid <= (grant==READ), registered.
  - Data reaches rd_data exactly 1 cycle after the request cycle.
  - Back-to-back reads sustain 1 per cycle.
- FIFO:
  - wr_ready = (count < DEPTH), computed from the registered count only.
  - When full, a same-cycle pop does not raise wr_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - Writes drain in FIFO order, one per non-read cycle.
- Hazards:
  - No forwarding. A read to an address with a write still queued returns the old BRAM contents.
  - The loader must wait for wr_idle before relying on read-back.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle where the FIFO is non-empty and rd_req=1.
  - Clears on any WRITE grant or when the FIFO is empty.
  - wr_starved = (counter == STARVE_LIMIT), a level signal.
- Reset mid-operation: queued writes are discarded and never reach the BRAM; an in-flight rd_valid is cleared.

Decomposition:
- Package vga_fb_pkg:
  - Default ADDR_BITS/DATA_W.
  - Grant encoding constants GNT_IDLE=2'd0, GNT_READ=2'd1, GNT_WRITE=2'd2.
  - Counter width function clog2(STARVE_LIMIT+1).
- Sub-module fb_wr_fifo:
  - Synchronous FIFO, width ADDR_BITS+DATA_W, depth DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
- The arbiter itself holds the grant mux, the rd_valid register and the starvation counter.

Test Plan:
- Reset then idle: ram_enable=0, wr_ready=1, wr_idle=1, rd_valid=0 for 10 cycles.
- Write 0xA5 to addr 0x0010 with rd_req=0 -> one cycle later ram_we=1, ram_addr=0x0010, ram_wdata=0xA5; wr_idle returns to 1.
- rd_req held high, then 5 writes offered: only 4 accepted (wr_ready=0 after 4th); ram_we stays 0; all 4 drain in order on the first 4 cycles after rd_req falls.
- Reads to addr 0,1,2 on consecutive cycles with BRAM model -> rd_valid high on cycles +1..+3, with rd_data = mem[0], mem[1], mem[2].
- STARVE_LIMIT=8, 1 write queued, rd_req high for 10 cycles -> wr_starved rises on cycle 8; clears the cycle after rd_req drops and the write is granted.
- 3 writes queued, reset asserted for 1 cycle -> none appear on the ram_* pins; count=0; wr_idle=1 after reset.
